// File: rtl/riscv_pkg.sv
// Shared constants for the pipeline stages: default widths, reset PC and the canonical NOP.
// No logic, so no latency.
// No flow control; constants only.
package riscv_pkg;

  localparam int          ADDRESS_BITS = 12;
  localparam int          DATA_WIDTH   = 32;
  localparam int          RESET_PC     = 0;
  localparam int          PC_INCREMENT = 4;

  // addi x0,x0,0: the bubble every pipeline register loads when squashed
  localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;

endpackage

// File: rtl/if_id_register.sv
// IF/ID pipeline register: instruction, its PC, PC+4 and a valid bit.
// One cycle: next_* fields are visible on the outputs after the next rising edge.
// bubble beats hold; a bubble keeps the pc fields and squashes the instruction to NOP.
module if_id_register
  import riscv_pkg::*;
#(
  parameter int address_bits = ADDRESS_BITS,
  parameter int data_width   = DATA_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    bubble,
  input  logic                    hold,
  input  logic [address_bits-1:0] next_pc,
  input  logic [address_bits-1:0] next_pc_plus4,
  input  logic [data_width-1:0]   next_instruction,
  output logic [address_bits-1:0] ifid_pc,
  output logic [address_bits-1:0] ifid_pc_plus4,
  output logic [data_width-1:0]   ifid_instruction,
  output logic                    ifid_valid
);

  localparam logic [data_width-1:0] NOP = data_width'(NOP_INSTR);

  // Bubble, hold or load, in that priority order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ifid_pc          <= '0;
      ifid_pc_plus4    <= '0;
      ifid_instruction <= NOP;
      ifid_valid       <= 1'b0;
    end else if (bubble) begin
      ifid_instruction <= NOP;
      ifid_valid       <= 1'b0;
    end else if (!hold) begin
      ifid_pc          <= next_pc;
      ifid_pc_plus4    <= next_pc_plus4;
      ifid_instruction <= next_instruction;
      ifid_valid       <= 1'b1;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC, next-PC selection, IF/ID capture, misalignment pulse and fetch counter.
// Instruction at pc appears in IF/ID one edge later; a redirect costs one bubble.
// stall holds PC and IF/ID; flush/redirect insert a bubble; redirect overrides stall.
module fetch_stage
  import riscv_pkg::*;
#(
  parameter int address_bits = ADDRESS_BITS,
  parameter int data_width   = DATA_WIDTH,
  parameter int reset_pc     = RESET_PC
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    stall,
  input  logic                    flush,
  input  logic                    redirect_valid,
  input  logic [address_bits-1:0] redirect_target,
  output logic [address_bits-1:0] imem_address,
  input  logic [data_width-1:0]   imem_instruction,
  output logic [address_bits-1:0] ifid_pc,
  output logic [address_bits-1:0] ifid_pc_plus4,
  output logic [data_width-1:0]   ifid_instruction,
  output logic                    ifid_valid,
  output logic                    misaligned_fault,
  output logic [31:0]             fetch_count
);

  logic [address_bits-1:0] pc;
  logic [address_bits-1:0] pc_plus4;
  logic [address_bits-1:0] pc_next;
  logic [address_bits-1:0] redirect_aligned;
  logic                    squash;
  logic                    fetch_accept;

  // Wraps modulo 2^address_bits by construction of the adder width.
  assign pc_plus4         = pc + address_bits'(PC_INCREMENT);
  // Low bits are dropped rather than trapped; the fault pulse reports them.
  assign redirect_aligned = {redirect_target[address_bits-1:2], 2'b00};
  assign squash           = redirect_valid | flush;
  assign fetch_accept     = !squash && !stall;
  assign imem_address     = pc;

  // Next PC: redirect beats stall beats sequential increment.
  always_comb begin
    pc_next = pc_plus4;
    if (redirect_valid) begin
      pc_next = redirect_aligned;
    end else if (stall) begin
      pc_next = pc;
    end
  end

  // Program counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= address_bits'(reset_pc);
    end else begin
      pc <= pc_next;
    end
  end

  // One-cycle fault pulse and count of instructions accepted into IF/ID.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      misaligned_fault <= 1'b0;
      fetch_count      <= '0;
    end else begin
      misaligned_fault <= redirect_valid && (redirect_target[1:0] != 2'b00);
      if (fetch_accept) begin
        fetch_count <= fetch_count + 32'd1;
      end
    end
  end

  if_id_register #(
    .address_bits(address_bits),
    .data_width  (data_width)
  ) u_if_id (
    .clk             (clk),
    .rst_n           (rst_n),
    .bubble          (squash),
    .hold            (stall),
    .next_pc         (pc),
    .next_pc_plus4   (pc_plus4),
    .next_instruction(imem_instruction),
    .ifid_pc         (ifid_pc),
    .ifid_pc_plus4   (ifid_pc_plus4),
    .ifid_instruction(ifid_instruction),
    .ifid_valid      (ifid_valid)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: behavioural model feeds a scoreboard queue of expected outputs.
// Each driven cycle pushes one expected record, popped and compared one edge later.
// Inputs change and outputs are sampled 1 time unit after the rising edge.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam int          VW  = 12 * 3 + 32 + 1 + 1 + 32;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, flush, redirect_valid;
  logic [11:0] redirect_target;
  logic [11:0] imem_address;
  logic [31:0] imem_instruction;
  logic [11:0] ifid_pc, ifid_pc_plus4;
  logic [31:0] ifid_instruction;
  logic        ifid_valid, misaligned_fault;
  logic [31:0] fetch_count;

  logic [31:0] mem [0:1023];

  int n_assert = 0;
  int n_fail   = 0;

  logic [VW-1:0] sb [$];
  logic [VW-1:0] exp_v;

  // model state
  logic [11:0] m_pc, m_ipc, m_ipc4;
  logic [31:0] m_instr, m_cnt;
  logic        m_vld, m_fault;

  always #5 clk = ~clk;

  assign imem_instruction = mem[imem_address[11:2]];

  fetch_stage dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .stall           (stall),
    .flush           (flush),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .imem_address    (imem_address),
    .imem_instruction(imem_instruction),
    .ifid_pc         (ifid_pc),
    .ifid_pc_plus4   (ifid_pc_plus4),
    .ifid_instruction(ifid_instruction),
    .ifid_valid      (ifid_valid),
    .misaligned_fault(misaligned_fault),
    .fetch_count     (fetch_count)
  );

  function automatic logic [VW-1:0] observed();
    return {imem_address, ifid_pc, ifid_pc_plus4, ifid_instruction, ifid_valid, misaligned_fault, fetch_count};
  endfunction

  task automatic model_reset();
    m_pc = 12'h000; m_ipc = 12'h000; m_ipc4 = 12'h000;
    m_instr = NOP; m_vld = 1'b0; m_fault = 1'b0; m_cnt = 32'd0;
    sb.delete();
  endtask

  task automatic do_reset();
    stall = 1'b0; flush = 1'b0; redirect_valid = 1'b0; redirect_target = 12'h000;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  // Drive one cycle of inputs, push the model's post-edge expectation, advance one edge.
  task automatic drive_cycle(input logic s, input logic f, input logic r, input logic [11:0] t);
    logic [31:0] w;
    stall = s; flush = f; redirect_valid = r; redirect_target = t;
    w = mem[m_pc[11:2]];
    if (r || f) begin
      m_instr = NOP; m_vld = 1'b0;
    end else if (!s) begin
      m_ipc = m_pc; m_ipc4 = m_pc + 12'd4; m_instr = w; m_vld = 1'b1;
      m_cnt = m_cnt + 32'd1;
    end
    m_fault = r && (t[1:0] != 2'b00);
    if (r)       m_pc = {t[11:2], 2'b00};
    else if (!s) m_pc = m_pc + 12'd4;
    sb.push_back({m_pc, m_ipc, m_ipc4, m_instr, m_vld, m_fault, m_cnt});
    @(posedge clk); #1;
    stall = 1'b0; flush = 1'b0; redirect_valid = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_assert++;
    if (observed() !== {12'h000, 12'h000, 12'h000, NOP, 1'b0, 1'b0, 32'd0}) begin
      n_fail++; $display("FAIL reset_state: got %h want %h", observed(), {12'h000, 12'h000, 12'h000, NOP, 1'b0, 1'b0, 32'd0});
    end
  endtask

  task automatic test_sequential();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive_cycle(1'b0, 1'b0, 1'b0, 12'h000);
      exp_v = sb.pop_front();
      n_assert++;
      if (observed() !== exp_v) begin
        n_fail++; $display("FAIL seq_cycle%0d: got %h want %h", i, observed(), exp_v);
      end
      n_assert++;
      if (ifid_instruction !== mem[i]) begin
        n_fail++; $display("FAIL seq_word%0d: got %h want %h", i, ifid_instruction, mem[i]);
      end
    end
    n_assert++;
    if (fetch_count !== 32'd4 || imem_address !== 12'h010) begin
      n_fail++; $display("FAIL seq_count: got cnt %0d addr %h want 4 010", fetch_count, imem_address);
    end
  endtask

  task automatic test_stall();
    do_reset();
    drive_cycle(1'b0, 1'b0, 1'b0, 12'h000);
    void'(sb.pop_front());
    drive_cycle(1'b0, 1'b0, 1'b0, 12'h000);
    void'(sb.pop_front());
    for (int i = 0; i < 2; i++) begin
      drive_cycle(1'b1, 1'b0, 1'b0, 12'h000);
      exp_v = sb.pop_front();
      n_assert++;
      if (observed() !== exp_v || imem_address !== 12'h008 || ifid_pc !== 12'h004
          || ifid_instruction !== mem[1] || fetch_count !== 32'd2) begin
        n_fail++; $display("FAIL stall_hold%0d: got %h want %h", i, observed(), exp_v);
      end
    end
    drive_cycle(1'b0, 1'b0, 1'b0, 12'h000);
    exp_v = sb.pop_front();
    n_assert++;
    if (observed() !== exp_v || imem_address !== 12'h00C || ifid_pc !== 12'h008 || ifid_instruction !== mem[2]) begin
      n_fail++; $display("FAIL stall_release: got %h want %h", observed(), exp_v);
    end
  endtask

  task automatic test_flush();
    do_reset();
    drive_cycle(1'b0, 1'b0, 1'b0, 12'h000);
    void'(sb.pop_front());
    drive_cycle(1'b0, 1'b1, 1'b0, 12'h000);
    exp_v = sb.pop_front();
    n_assert++;
    if (observed() !== exp_v || ifid_valid !== 1'b0 || imem_address !== 12'h008) begin
      n_fail++; $display("FAIL flush_only: got %h want %h", observed(), exp_v);
    end
    drive_cycle(1'b1, 1'b1, 1'b0, 12'h000);
    exp_v = sb.pop_front();
    n_assert++;
    if (observed() !== exp_v || imem_address !== 12'h008 || ifid_instruction !== NOP) begin
      n_fail++; $display("FAIL stall_flush: got %h want %h", observed(), exp_v);
    end
  endtask

  task automatic test_redirect();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive_cycle(1'b0, 1'b0, 1'b0, 12'h000);
      void'(sb.pop_front());
    end
    drive_cycle(1'b0, 1'b0, 1'b1, 12'h040);
    exp_v = sb.pop_front();
    n_assert++;
    if (observed() !== exp_v || imem_address !== 12'h040 || ifid_valid !== 1'b0 || ifid_instruction !== NOP) begin
      n_fail++; $display("FAIL redirect: got %h want %h", observed(), exp_v);
    end
    drive_cycle(1'b0, 1'b0, 1'b0, 12'h000);
    exp_v = sb.pop_front();
    n_assert++;
    if (observed() !== exp_v || ifid_pc !== 12'h040) begin
      n_fail++; $display("FAIL redirect_follow: got %h want %h", observed(), exp_v);
    end
    drive_cycle(1'b1, 1'b1, 1'b1, 12'h040);
    exp_v = sb.pop_front();
    n_assert++;
    if (observed() !== exp_v || imem_address !== 12'h040 || ifid_valid !== 1'b0) begin
      n_fail++; $display("FAIL redirect_stall: got %h want %h", observed(), exp_v);
    end
  endtask

  task automatic test_misaligned();
    do_reset();
    drive_cycle(1'b0, 1'b0, 1'b1, 12'h046);
    exp_v = sb.pop_front();
    n_assert++;
    if (observed() !== exp_v || imem_address !== 12'h044 || misaligned_fault !== 1'b1) begin
      n_fail++; $display("FAIL misaligned_pulse: got %h want %h", observed(), exp_v);
    end
    drive_cycle(1'b0, 1'b0, 1'b0, 12'h000);
    exp_v = sb.pop_front();
    n_assert++;
    if (observed() !== exp_v || misaligned_fault !== 1'b0) begin
      n_fail++; $display("FAIL misaligned_clear: got %h want %h", observed(), exp_v);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    drive_cycle(1'b0, 1'b0, 1'b1, 12'hFFC);
    void'(sb.pop_front());
    drive_cycle(1'b0, 1'b0, 1'b0, 12'h000);
    exp_v = sb.pop_front();
    n_assert++;
    if (observed() !== exp_v || imem_address !== 12'h000 || ifid_pc !== 12'hFFC
        || ifid_pc_plus4 !== 12'h000 || ifid_instruction !== mem[1023]) begin
      n_fail++; $display("FAIL pc_wrap: got %h want %h", observed(), exp_v);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive_cycle(1'b0, 1'b0, 1'b0, 12'h000);
      void'(sb.pop_front());
    end
    #2 rst_n = 1'b0;
    #1;
    n_assert++;
    if (observed() !== {12'h000, 12'h000, 12'h000, NOP, 1'b0, 1'b0, 32'd0}) begin
      n_fail++; $display("FAIL async_reset: got %h want %h", observed(), {12'h000, 12'h000, 12'h000, NOP, 1'b0, 1'b0, 32'd0});
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
    drive_cycle(1'b0, 1'b0, 1'b0, 12'h000);
    exp_v = sb.pop_front();
    n_assert++;
    if (observed() !== exp_v || ifid_pc !== 12'h000 || ifid_instruction !== mem[0] || fetch_count !== 32'd1) begin
      n_fail++; $display("FAIL reset_restart: got %h want %h", observed(), exp_v);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'h1000_0000 + i * 32'h111;
    stall = 1'b0; flush = 1'b0; redirect_valid = 1'b0; redirect_target = 12'h000;
    rst_n = 1'b0;
    #1;
    test_reset();
    test_sequential();
    test_stall();
    test_flush();
    test_redirect();
    test_misaligned();
    test_wrap();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
